// File: rtl/instr_encoder.sv
// RV32I field packer with sequential imem address tagging into a small output FIFO; optional IMM_RANGE_CHECK_EN flags out-of-range immediates.
// Latency: accepted word is at the FIFO head the next cycle (registered storage, no fall-through).
// Backpressure: in_ready drops when the FIFO holds DEPTH entries, regardless of a same-cycle pop.

module instr_encoder_fifo #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_rdy = (count != CNT_W'(DEPTH));
  assign rd_vld = (count != '0);
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  // Storage is reset too, so the head shows RST_VAL while empty after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_VAL;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module instr_encoder #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        err_sticky
);

  localparam logic [2:0]  FMT_I = 3'b000;
  localparam logic [2:0]  FMT_S = 3'b001;
  localparam logic [2:0]  FMT_B = 3'b010;
  localparam logic [2:0]  FMT_J = 3'b011;
  localparam logic [2:0]  FMT_U = 3'b100;
  localparam logic [2:0]  FMT_R = 3'b111;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] instr;
  } entry_t;

  logic [31:0] enc_instr;
  logic        fmt_illegal;
  logic        imm_bad;
  logic        enc_err;
  logic [31:0] next_addr;
  logic        push;
  entry_t      wr_entry;
  entry_t      head;

  always_comb begin
    enc_instr   = NOP;
    fmt_illegal = 1'b0;
    case (in_fmt)
      FMT_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
      FMT_I: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
      FMT_S: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
      FMT_B: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_op};
      FMT_U: enc_instr = {in_imm[31:12], in_rd, in_op};
      FMT_J: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
      default: begin
        enc_instr   = NOP;
        fmt_illegal = 1'b1;
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Signed range holds when all bits above the sign bit replicate it.
  always_comb begin
    imm_bad = 1'b0;
    case (in_fmt)
      FMT_I, FMT_S: imm_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      FMT_B:        imm_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      FMT_J:        imm_bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      FMT_U:        imm_bad = (in_imm[11:0] != 12'h000);
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign enc_err = fmt_illegal || imm_bad;
  assign push    = in_valid && in_ready;

  assign wr_entry = '{err: enc_err, addr: next_addr, instr: enc_instr};

  always_ff @(posedge clk) begin
    if (reset) begin
      next_addr  <= BASE_ADDR;
      err_sticky <= 1'b0;
    end else if (push) begin
      next_addr  <= next_addr + 32'd4;
      err_sticky <= err_sticky || enc_err;
    end
  end

  instr_encoder_fifo #(
    .WIDTH   ($bits(entry_t)),
    .DEPTH   (DEPTH),
    .RST_VAL ({1'b0, BASE_ADDR, 32'h0000_0000})
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (wr_entry),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (head)
  );

  assign out_instr = head.instr;
  assign out_addr  = head.addr;
  assign out_err   = head.err;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings, backpressure, reset and randomized traffic against a queue model.
module tb_instr_encoder;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] TB_BASE = 32'hFFFF_FFF8;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_sticky;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(TB_BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_addr = TB_BASE;
  logic        m_sticky = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          last_acc;

  function automatic longint unsigned fld(input longint unsigned x, input int lo, input int n);
    return (x >> lo) & ((64'd1 << n) - 64'd1);
  endfunction

  // Reference encoding from bit positions of the RV32I formats, as arithmetic on integers.
  function automatic logic [32:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    longint unsigned u, w;
    longint          s;
    bit              bad;
    u   = {32'd0, imm};
    s   = longint'($signed(imm));
    bad = 1'b0;
    case (fmt)
      3'd0: begin
        w   = 64'(op) + (64'(rd) << 7) + (64'(f3) << 12) + (64'(rs1) << 15) + (fld(u, 0, 12) << 20);
        bad = CHK && (s < -2048 || s > 2047);
      end
      3'd1: begin
        w   = 64'(op) + (fld(u, 0, 5) << 7) + (64'(f3) << 12) + (64'(rs1) << 15)
            + (64'(rs2) << 20) + (fld(u, 5, 7) << 25);
        bad = CHK && (s < -2048 || s > 2047);
      end
      3'd2: begin
        w   = 64'(op) + (fld(u, 11, 1) << 7) + (fld(u, 1, 4) << 8) + (64'(f3) << 12)
            + (64'(rs1) << 15) + (64'(rs2) << 20) + (fld(u, 5, 6) << 25) + (fld(u, 12, 1) << 31);
        bad = CHK && (s < -4096 || s > 4095 || (u % 2) != 0);
      end
      3'd3: begin
        w   = 64'(op) + (64'(rd) << 7) + (fld(u, 12, 8) << 12) + (fld(u, 11, 1) << 20)
            + (fld(u, 1, 10) << 21) + (fld(u, 20, 1) << 31);
        bad = CHK && (s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 1 || (u % 2) != 0);
      end
      3'd4: begin
        w   = 64'(op) + (64'(rd) << 7) + (fld(u, 12, 20) << 12);
        bad = CHK && ((u % 4096) != 0);
      end
      3'd7: begin
        w = 64'(op) + (64'(rd) << 7) + (64'(f3) << 12) + (64'(rs1) << 15)
          + (64'(rs2) << 20) + (64'(f7) << 25);
      end
      default: begin
        w   = 64'h13;
        bad = 1'b1;
      end
    endcase
    return {bad, w[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare();
    check("in_ready", {31'd0, in_ready}, {31'd0, q.size() != DEPTH});
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    check("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
    if (q.size() != 0) begin
      check("head instr", out_instr, q[0].instr);
      check("head addr", out_addr, q[0].addr);
      check("head err", {31'd0, out_err}, {31'd0, q[0].err});
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge, return #1 after it.
  task automatic tick();
    bit          acc, pop;
    logic [32:0] r;
    @(negedge clk);
    compare();
    acc = in_valid && (q.size() < DEPTH);
    pop = out_ready && (q.size() > 0);
    r   = ref_encode(in_fmt, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    @(posedge clk);
    last_acc = acc && !reset;
    if (reset) begin
      q.delete();
      m_addr   = TB_BASE;
      m_sticky = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back('{instr: r[31:0], addr: m_addr, err: r[32]});
        m_addr   = m_addr + 32'd4;
        m_sticky = m_sticky | r[32];
      end
    end
    #1;
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic rand_fields();
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      2: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      default: imm = $urandom & 32'hFFFF_F000;
    endcase
    drive(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          3'($urandom), 7'($urandom), imm);
  endtask

  task automatic directed(input string name, input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp_word, input bit exp_err);
    logic [32:0] r;
    logic [31:0] exp_addr;
    exp_addr = m_addr;
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    r = ref_encode(fmt, op, rd, rs1, rs2, f3, f7, imm);
    check({name, " model word"}, r[31:0], exp_word);
    check({name, " model err"}, {31'd0, r[32]}, {31'd0, exp_err});
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check({name, " word"}, out_instr, exp_word);
    check({name, " err"}, {31'd0, out_err}, {31'd0, exp_err});
    check({name, " addr"}, out_addr, exp_addr);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_instr", out_instr, 32'd0);
    check("rst out_addr", out_addr, TB_BASE);
    check("rst out_err", {31'd0, out_err}, 32'd0);
    check("rst err_sticky", {31'd0, err_sticky}, 32'd0);

    directed("addi", 3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    directed("add",  3'b111, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
    directed("sw",   3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
    directed("beq",  3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFE00_0EE3, 1'b0);
    directed("lui",  3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    directed("jal",  3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
    check("sticky clean", {31'd0, err_sticky}, 32'd0);
    directed("illegal", 3'b101, 7'h33, 5'd7, 5'd2, 5'd3, 3'd1, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    check("sticky set", {31'd0, err_sticky}, 32'd1);
    directed("imm2048", 3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, CHK);
    check("sticky held", {31'd0, err_sticky}, 32'd1);

    // Backpressure: three requests into a two-entry FIFO with the consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_fields();
    tick();
    rand_fields();
    tick();
    check("bp full in_ready", {31'd0, in_ready}, 32'd0);
    check("bp head addr", out_addr, m_addr - 32'd8);
    rand_fields();
    tick();
    out_ready = 1'b1;
    guard = 0;
    last_acc = 1'b0;
    while (!last_acc && guard < 10) begin
      tick();
      guard++;
    end
    if (!last_acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL bp third push: not accepted within 10 cycles");
    end
    in_valid = 1'b0;
    repeat (4) tick();
    out_ready = 1'b0;

    // Reset with two entries buffered.
    in_valid = 1'b1;
    rand_fields();
    tick();
    rand_fields();
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-rst err_sticky", {31'd0, err_sticky}, 32'd0);
    check("mid-rst out_addr", out_addr, TB_BASE);
    in_valid = 1'b1;
    rand_fields();
    tick();
    in_valid = 1'b0;
    check("post-rst addr", out_addr, TB_BASE);

    for (int i = 0; i < 3000; i++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
